// File: rtl/clk_vec_edge_monitor.sv
// Per-channel synchronised rising-edge detector with a windowed edge counter on one selected channel.
// Optional CLK_MON_GLITCH_FILTER_EN: a level must match on two consecutive samples before it is accepted.
module clk_vec_edge_monitor #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NCH-1:0]                           i_clks,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] i_sel,
  input  logic [WIN_W-1:0]                         i_window,
  input  logic                                     i_start,
  output logic                                     o_busy,
  output logic [NCH-1:0]                           o_edges,
  output logic [CNT_W-1:0]                         o_count,
  output logic                                     o_sat,
  output logic                                     o_valid,
  input  logic                                     i_ready
);

  localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
  logic [NCH-1:0]                  sync_lvl_c;
  logic [NCH-1:0]                  lvl_c;
  logic [NCH-1:0]                  prev_q;

  state_t                          state_q, state_d;
  logic [SEL_W-1:0]                sel_q, sel_d;
  logic [WIN_W-1:0]                win_q, win_d;
  logic [CNT_W-1:0]                count_d;
  logic                            sat_d;
  logic                            valid_d;
  logic                            busy_d;
  logic                            sel_edge_c;

  // Multi-flop synchroniser, stage 0 samples the asynchronous inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_clks};
    end
  end

  assign sync_lvl_c = sync_q[SYNC_STAGES-1];

`ifdef CLK_MON_GLITCH_FILTER_EN
  logic [NCH-1:0] stab_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_q <= '0;
    end else begin
      stab_q <= sync_lvl_c;
    end
  end

  // Accept the new level only when two consecutive samples agree, otherwise keep the old one
  assign lvl_c = (sync_lvl_c & ~(sync_lvl_c ^ stab_q)) | (prev_q & (sync_lvl_c ^ stab_q));
`else
  assign lvl_c = sync_lvl_c;
`endif

  // Edge detect runs continuously, independent of the measurement FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      o_edges <= '0;
    end else begin
      prev_q  <= lvl_c;
      o_edges <= lvl_c & ~prev_q;
    end
  end

  // Out-of-range selections never match, so they count nothing
  always_comb begin
    sel_edge_c = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_edge_c = o_edges[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      win_q   <= '0;
      o_count <= '0;
      o_sat   <= 1'b0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      win_q   <= win_d;
      o_count <= count_d;
      o_sat   <= sat_d;
      o_valid <= valid_d;
      o_busy  <= busy_d;
    end
  end

  // Next state and next values of the registered result outputs
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    win_d   = win_q;
    count_d = o_count;
    sat_d   = o_sat;
    valid_d = o_valid;
    busy_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          sel_d   = i_sel;
          win_d   = i_window;
          count_d = '0;
          sat_d   = 1'b0;
          state_d = (i_window == '0) ? HOLD : MEAS;
        end
      end
      MEAS: begin
        if (sel_edge_c && (o_count != CNT_MAX)) begin
          count_d = o_count + CNT_W'(1);
          if (o_count == (CNT_MAX - CNT_W'(1))) begin
            sat_d = 1'b1;
          end
        end
        win_d = win_q - WIN_W'(1);
        // Last window cycle: its edge is already counted above
        if (win_q == WIN_W'(1)) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        valid_d = 1'b1;
        if (o_valid && i_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
